// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index k holds the pattern for decimal digit k.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_enc.sv
// Combinational BCD to active-low seven-segment encoder.
// Codes above 9 are shown as a dash.
module seg7_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_DASH;
    if (bcd_i <= 4'd9) begin
      seg_n_o = SEG_DIGITS[bcd_i];
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with per-digit
// blanking window and leading-zero suppression.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  output logic [2:0]              digit_sel,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  // DIV must be at least BLANK_CYCLES+2 so every digit gets a lit phase.
  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       SEL_LAST       = 3'(NUM_DIGITS - 1);

  scan_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       digit_sel_q;
  logic [6:0]       seg_n_q;
  logic             dp_n_q;
  logic             frame_done_q;

  logic [2:0]       digit_sel_d;
  logic [6:0]       seg_show_d;
  logic             dp_show_d;
  logic             lz_hit_d;
  logic             zero_above;
  logic [6:0]       enc_seg;

  // Pad the digit bus to a full 8 slots so a 3-bit index is always in range.
  logic [3:0] nib_all [8];
  logic [7:0] dp_all;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_DIGITS) begin : g_live
        assign nib_all[gi] = digits_bcd[4*gi +: 4];
        assign dp_all[gi]  = dp_mask[gi];
      end else begin : g_unused
        assign nib_all[gi] = 4'h0;
        assign dp_all[gi]  = 1'b0;
      end
    end
  endgenerate

  // Selected digit is a leading zero when it and every higher nibble are 0.
  always_comb begin
    lz_hit_d   = 1'b0;
    zero_above = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      zero_above = zero_above & (nib_all[k] == 4'h0);
      if (digit_sel_q == 3'(k)) begin
        lz_hit_d = zero_above;
      end
    end
    lz_hit_d = lz_hit_d & lz_blank;
  end

  seg7_enc u_enc (
    .bcd_i   (nib_all[digit_sel_q]),
    .seg_n_o (enc_seg)
  );

  assign seg_show_d  = lz_hit_d ? SEG_BLANK : enc_seg;
  assign dp_show_d   = ~dp_all[digit_sel_q];
  assign digit_sel_d = (digit_sel_q == SEL_LAST) ? 3'd0 : digit_sel_q + 3'd1;

  // The lit pattern is captured into seg_n_q/dp_n_q at the end of the blank
  // window and held for the whole dwell, so later input changes cannot tear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      digit_sel_q  <= 3'd0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          seg_n_q <= SEG_BLANK;
          dp_n_q  <= 1'b1;
          if (en) begin
            state_q <= BLANK;
          end
        end
        BLANK: begin
          if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_n_q <= SEG_BLANK;
            dp_n_q  <= 1'b1;
          end else if (cnt_q == CNT_BLANK_LAST) begin
            state_q <= SHOW;
            cnt_q   <= cnt_q + CNT_W'(1);
            seg_n_q <= seg_show_d;
            dp_n_q  <= dp_show_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SHOW: begin
          if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            seg_n_q <= SEG_BLANK;
            dp_n_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= (digit_sel_q == SEL_LAST);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          seg_n_q <= SEG_BLANK;
          dp_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign digit_sel  = digit_sel_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: per-cycle expected outputs are queued
// as stimulus is applied and compared one cycle at a time by a monitor.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] digits_bcd;
  logic [7:0]  dp_mask;
  logic        lz_blank;
  logic [2:0]  digit_sel;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  seg7_scan_ctrl #(
    .CLK_HZ       (1000),
    .SCAN_HZ      (100),
    .NUM_DIGITS   (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .digits_bcd (digits_bcd),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .digit_sel  (digit_sel),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [6:0] seg;
    logic       dpn;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [31:0]     digits;
    logic [7:0]      dp;
    logic            lz;
    logic [7:0][6:0] seg;
    logic [7:0]      dpn;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   exp_idx  = 0;

  // One expected record per clock, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (digit_sel !== mon_e.sel || seg_n !== mon_e.seg ||
          dp_n !== mon_e.dpn || frame_done !== mon_e.fd) begin
        failures++;
        $display("FAIL scan#%0d got sel=%0d seg=%h dp_n=%b fd=%b required sel=%0d seg=%h dp_n=%b fd=%b",
                 exp_idx, digit_sel, seg_n, dp_n, frame_done,
                 mon_e.sel, mon_e.seg, mon_e.dpn, mon_e.fd);
      end
      exp_idx++;
    end
  end

  task automatic push1(input logic [2:0] sel, input logic [6:0] seg,
                       input logic dpn, input logic fd);
    exp_t e;
    e.sel = sel; e.seg = seg; e.dpn = dpn; e.fd = fd;
    exp_q.push_back(e);
  endtask

  // Blank cycles of a digit plus the first n_lit lit cycles.
  task automatic push_digit(input logic [2:0] sel, input logic [6:0] seg,
                            input logic dpn, input logic fd, input int n_lit);
    push1(sel, 7'h7F, 1'b1, fd);
    push1(sel, 7'h7F, 1'b1, 1'b0);
    for (int i = 0; i < n_lit; i++) push1(sel, seg, dpn, 1'b0);
  endtask

  task automatic push_frame(input vec_t v, input logic fd_first);
    for (int d = 0; d < 8; d++)
      push_digit(3'(d), v.seg[d], v.dpn[d], (d == 0) ? fd_first : 1'b0, 8);
  endtask

  task automatic apply(input vec_t v);
    digits_bcd = v.digits;
    dp_mask    = v.dp;
    lz_blank   = v.lz;
  endtask

  // Returns on a falling edge once every queued expectation has been checked.
  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0) begin
      if (n == budget) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout got pending=%0d required pending=0", exp_q.size());
        exp_q.delete();
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int   n;

    vecs[0] = '{32'h76543210, 8'h00, 1'b0,
                {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF};
    vecs[1] = '{32'h0000000A, 8'h01, 1'b0,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h3F}, 8'hFE};
    vecs[2] = '{32'h00000105, 8'h00, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12}, 8'hFF};
    vecs[3] = '{32'h00000000, 8'h00, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFF};
    vecs[4] = '{32'h00000000, 8'h80, 1'b1,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'h7F};
    vecs[5] = '{32'h98765432, 8'hAA, 1'b1,
                {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24}, 8'h55};
    vecs[6] = '{32'h0F000B00, 8'h00, 1'b1,
                {7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h40, 7'h40}, 8'hFF};

    rst = 1'b1;
    en  = 1'b0;
    apply(vecs[0]);
    push1(3'd0, 7'h7F, 1'b1, 1'b0);
    push1(3'd0, 7'h7F, 1'b1, 1'b0);
    wait_drain(10);

    // Table-driven frames, applied back to back at frame boundaries.
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i]);
      push_frame(vecs[i], (i > 0));
      wait_drain(100);
    end

    // Input change in the middle of digit 3's lit phase must not tear it.
    v = '{32'h11111111, 8'h00, 1'b0,
          {7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79}, 8'hFF};
    apply(v);
    push_frame(v, 1'b1);
    wait_drain(100);
    v.seg = {7'h00, 7'h00, 7'h00, 7'h00, 7'h79, 7'h79, 7'h79, 7'h79};
    push_frame(v, 1'b1);
    n = 0;
    while (exp_q.size() > 45 && n < 100) begin
      @(negedge clk);
      n++;
    end
    digits_bcd = 32'h88888888;
    wait_drain(100);

    // Enable drop inside digit 5's lit phase, then resume at digit 5.
    apply(vecs[0]);
    for (int d = 0; d < 5; d++)
      push_digit(3'(d), vecs[0].seg[d], 1'b1, (d == 0), 8);
    push_digit(3'd5, 7'h12, 1'b1, 1'b0, 3);
    wait_drain(100);
    en = 1'b0;
    for (int i = 0; i < 3; i++) push1(3'd5, 7'h7F, 1'b1, 1'b0);
    wait_drain(10);
    en = 1'b1;
    push_digit(3'd5, 7'h12, 1'b1, 1'b0, 8);
    push_digit(3'd6, 7'h02, 1'b1, 1'b0, 3);
    wait_drain(100);

    // Reset while lit with en still high.
    rst = 1'b1;
    push1(3'd0, 7'h7F, 1'b1, 1'b0);
    wait_drain(10);
    rst = 1'b0;
    push_digit(3'd0, 7'h40, 1'b1, 1'b0, 8);
    push_digit(3'd1, 7'h79, 1'b1, 1'b0, 8);
    wait_drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the stopwatch's 8-digit seven-segment display.
- Each scan tick it steps a 3-bit digit index. That index drives the downstream 3-to-8 anode decoder, whose outputs are active-low.
- It drives active-low segment and decimal-point lines for the selected digit.
- It inserts a blanking interval at every digit change to suppress ghosting, and supports leading-zero suppression.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- SCAN_HZ, 1000, per-digit dwell rate; DIV = CLK_HZ/SCAN_HZ clocks per digit. Legal only if DIV >= BLANK_CYCLES+2.
- NUM_DIGITS, 8, digits scanned, 2..8.
- BLANK_CYCLES, 16, clocks of all-segments-off after each digit change, >= 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- digits_bcd  in  4*NUM_DIGITS  BCD digits; nibble k is digit k; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit k.
- lz_blank  in  1  1 = suppress leading zeros.
- digit_sel  out  3  index to the 3-to-8 anode decoder.
- seg_n  out  7  active-low {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- frame_done  out  1  one-cycle pulse when digit_sel wraps to 0.

Behaviour:
- Reset (rst=1 at edge):
  - digit_sel=0, seg_n=7'h7F, dp_n=1, frame_done=0.
  - prescaler=0, FSM=IDLE.
  - rst overrides en and all other inputs.
- FSM states IDLE, BLANK, SHOW. prescaler cnt runs 0..DIV-1 in BLANK/SHOW; cleared in IDLE.
- IDLE:
  - seg_n=7F, dp_n=1, digit_sel held.
  - en=1 -> BLANK with cnt=0.
- BLANK:
  - seg_n=7F, dp_n=1.
  - When cnt==BLANK_CYCLES-1, the following are latched and the FSM moves to SHOW:
    - the nibble of digits_bcd at digit_sel;
    - its dp_mask bit;
    - its leading-zero blank flag.
- SHOW:
  - Outputs are driven from the latched values only, so input changes mid-dwell do not tear the display.
  - When cnt==DIV-1:
    - cnt->0;
    - digit_sel -> digit_sel+1, wrapping NUM_DIGITS-1 -> 0;
    - FSM -> BLANK.
- Total dwell per digit is exactly DIV clocks: BLANK_CYCLES blank, DIV-BLANK_CYCLES lit.
- frame_done=1 for exactly the cycle after digit_sel is written 0 by a wrap. It is not asserted after reset or re-enable.
- en=0 in BLANK/SHOW: the next edge goes to IDLE, seg_n=7F, dp_n=1, cnt=0, digit_sel held. Re-enable resumes at the held digit, starting with BLANK.
- Segment encoding, registered; seg_n changes on the same edge as the state change:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibbles A-F display a dash: seg_n=3F.
- Leading-zero suppression, evaluated at latch time:
  - Digit k is blanked when lz_blank=1, k != 0, and every nibble k..NUM_DIGITS-1 equals 0.
  - A blanked digit shows seg_n=7F.
  - Its dp is still honoured.
  - Digit 0 is never suppressed.
- dp_n = ~latched dp bit in SHOW; 1 otherwise.
- digit_sel is a registered output that changes only on SHOW->BLANK transitions, so the anode switch always falls inside a blank window.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK=7'h7F, SEG_DASH=7'h3F;
  - constant array of the ten digit codes;
  - enum scan_state_t {IDLE, BLANK, SHOW}.
- Sub-module seg7_enc: combinational 4-bit BCD -> 7-bit active-low pattern, including the dash for invalid codes. Instantiated once inside seg7_scan_ctrl.

Test Plan:
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2, NUM_DIGITS=8.
- Reset/scan: digits_bcd=32'h76543210, en=1 after reset.
  - digit_sel steps 0..7 every 10 clocks.
  - Each digit shows seg_n=7F for 2 clocks, then its code for 8 clocks (digit 1: 79 for 8 clocks).
  - frame_done pulses once per 80 clocks, the cycle after the 7->0 wrap.
- Invalid/dp: digits_bcd=32'h0000000A, dp_mask=8'h01.
  - Digit 0 shows seg_n=3F with dp_n=0.
  - Other digits show 40 with dp_n=1.
- Leading zeros: lz_blank=1, digits_bcd=32'h00000105.
  - Digits 7..3 show 7F.
  - Digit 2 shows 79, digit 1 shows 40, digit 0 shows 12.
  - digits_bcd=0 -> only digit 0 shows 40.
- No tearing: change digits_bcd from 32'h11111111 to 32'h88888888 mid-SHOW of digit 3.
  - Digit 3 keeps 79 until its dwell ends.
  - Digit 4 shows 00.
- Enable drop: deassert en in SHOW of digit 5.
  - Next cycle seg_n=7F, dp_n=1, digit_sel=5 held.
  - Reassert -> 2 blank clocks, then digit 5 for 8 clocks, then digit 6.
- Reset mid-operation: rst=1 in SHOW of digit 6 with en=1.
  - Next edge: digit_sel=0, seg_n=7F, frame_done=0.
  - After release: BLANK for 2 clocks, then digit 0.
